// File: rtl/id_ex_stage_reg_if.sv
// id_ex_stage_reg_if: decode-side inputs and EX-side outputs of the ID/EX register.
interface id_ex_stage_reg_if #(parameter int XLEN = 32, parameter int CNT_W = 16);
    logic             hold, flush_e;
    logic [4:0]       rs1_d, rs2_d, rd_d;
    logic             use_rs1_d, use_rs2_d;
    logic             regwrite_d, memread_d, memwrite_d;
    logic [XLEN-1:0]  rd1_d, rd2_d, imm_d, pc_d;
    logic [4:0]       rs1_e, rs2_e, rd_e;
    logic             regwrite_e, memread_e, memwrite_e, valid_e;
    logic [XLEN-1:0]  rd1_e, rd2_e, imm_e, pc_e;
    logic             stall_f, stall_d;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    modport master (
        output hold, flush_e, rs1_d, rs2_d, rd_d, use_rs1_d, use_rs2_d,
               regwrite_d, memread_d, memwrite_d, rd1_d, rd2_d, imm_d, pc_d,
        input  rs1_e, rs2_e, rd_e, regwrite_e, memread_e, memwrite_e, valid_e,
               rd1_e, rd2_e, imm_e, pc_e, stall_f, stall_d, stall_cnt, flush_cnt
    );
    modport slave (
        input  hold, flush_e, rs1_d, rs2_d, rd_d, use_rs1_d, use_rs2_d,
               regwrite_d, memread_d, memwrite_d, rd1_d, rd2_d, imm_d, pc_d,
        output rs1_e, rs2_e, rd_e, regwrite_e, memread_e, memwrite_e, valid_e,
               rd1_e, rd2_e, imm_e, pc_e, stall_f, stall_d, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with load-use bubble insertion,
// branch squash and saturating stall/flush event counters.
module id_ex_stage_reg #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input logic              clk,
    input logic              rst_n,
    id_ex_stage_reg_if.slave bus
);
    logic             w_load_use, w_bubble;
    logic [4:0]       r_rs1, r_rs2, r_rd;
    logic             r_regwrite, r_memread, r_memwrite, r_valid;
    logic [XLEN-1:0]  r_rd1, r_rd2, r_imm, r_pc;
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    assign w_load_use = r_memread && (r_rd != 5'd0) &&
                        ((bus.use_rs1_d && bus.rs1_d == r_rd) || (bus.use_rs2_d && bus.rs2_d == r_rd));
    assign w_bubble   = bus.flush_e || w_load_use;
    assign bus.stall_f = w_load_use && !bus.flush_e && !bus.hold;
    assign bus.stall_d = bus.stall_f;

    // Hold freezes everything; otherwise a flush or load-use bubble zeroes every field.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_regwrite  <= 1'b0;
            r_memread   <= 1'b0;
            r_memwrite  <= 1'b0;
            r_valid     <= 1'b0;
            r_rd1       <= '0;
            r_rd2       <= '0;
            r_imm       <= '0;
            r_pc        <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (!bus.hold) begin
            r_rs1      <= w_bubble ? 5'd0 : bus.rs1_d;
            r_rs2      <= w_bubble ? 5'd0 : bus.rs2_d;
            r_rd       <= w_bubble ? 5'd0 : bus.rd_d;
            r_regwrite <= !w_bubble && bus.regwrite_d;
            r_memread  <= !w_bubble && bus.memread_d;
            r_memwrite <= !w_bubble && bus.memwrite_d;
            r_valid    <= !w_bubble;
            r_rd1      <= w_bubble ? '0 : bus.rd1_d;
            r_rd2      <= w_bubble ? '0 : bus.rd2_d;
            r_imm      <= w_bubble ? '0 : bus.imm_d;
            r_pc       <= w_bubble ? '0 : bus.pc_d;
            if (bus.flush_e && !(&r_flush_cnt))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            if (!bus.flush_e && w_load_use && !(&r_stall_cnt))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign bus.rs1_e      = r_rs1;
    assign bus.rs2_e      = r_rs2;
    assign bus.rd_e       = r_rd;
    assign bus.regwrite_e = r_regwrite;
    assign bus.memread_e  = r_memread;
    assign bus.memwrite_e = r_memwrite;
    assign bus.valid_e    = r_valid;
    assign bus.rd1_e      = r_rd1;
    assign bus.rd2_e      = r_rd2;
    assign bus.imm_e      = r_imm;
    assign bus.pc_e       = r_pc;
    assign bus.stall_cnt  = r_stall_cnt;
    assign bus.flush_cnt  = r_flush_cnt;
endmodule

// File: doc/id_ex_stage_reg.md
# id_ex_stage_reg

ID/EX pipeline register of the 5-stage RV32I core, combined with load-use hazard detection. It captures decode-stage operands and control each cycle. It inserts a one-cycle bubble when an instruction in ID needs a load result still in EX, and squashes EX on a branch flush. Its rs1_e/rs2_e/rd_e/regwrite_e outputs feed the EX-stage RAW data forwarder.

## Interface
Parameters:
- XLEN, 32, datapath width
- CNT_W, 16, width of the stall and flush event counters

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- hold  in  1  global freeze (memory wait); highest priority
- flush_e  in  1  branch/jump redirect resolved in EX; squash next EX content
- rs1_d, rs2_d, rd_d  in  5 each  decode register indices
- use_rs1_d, use_rs2_d  in  1 each  decoded instruction actually reads rs1/rs2
- regwrite_d, memread_d, memwrite_d  in  1 each  decode control
- rd1_d, rd2_d, imm_d, pc_d  in  XLEN each  decode data
- rs1_e, rs2_e, rd_e  out  5 each  EX register indices (to forwarder)
- regwrite_e, memread_e, memwrite_e  out  1 each  EX control
- rd1_e, rd2_e, imm_e, pc_e  out  XLEN each  EX data
- valid_e  out  1  EX holds a real instruction (not a bubble)
- stall_f, stall_d  out  1 each  hold PC and IF/ID register
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters

## Operation
- load_use = memread_e && rd_e != 0 && ((use_rs1_d && rs1_d == rd_e) || (use_rs2_d && rs2_d == rd_e)); combinational.
- stall_f = stall_d = load_use && !flush_e && !hold.
- The register update has four cases, in priority order:
  - hold: all EX registers and both counters keep their values.
  - flush_e: EX loads a bubble; flush_cnt increments.
  - load_use: EX loads a bubble; stall_cnt increments.
  - otherwise: EX loads all *_d inputs, and valid_e <= 1.
- Bubble contents: rs1_e = rs2_e = rd_e = 0, regwrite_e = memread_e = memwrite_e = 0, valid_e = 0. Data fields rd1_e/rd2_e/imm_e/pc_e are also zeroed, so bubbles are deterministic.
- Counters saturate at all-ones and never wrap.
- A load whose rd = x0 never causes a stall.
- A non-load writer in EX never causes a stall. Forwarding resolves that case.
- When flush_e and load_use are both true, flush wins: bubble inserted, no stall, only flush_cnt increments.
- While hold is high, flush_e is ignored. The branch unit keeps flush_e asserted until hold drops.

## Timing
- Reset (asynchronous assert, synchronous-release registers): every EX output is 0, valid_e = 0, and both counters are 0. stall_f/stall_d are therefore 0, because memread_e = 0.
- Latency is one cycle: *_d sampled at edge N appears on *_e after edge N.
- stall_f/stall_d are valid in the same cycle the hazard exists. Upstream uses them at the next edge.
- A load-use stall lasts exactly one cycle: after the bubble, memread_e = 0, so load_use clears. The dependent instruction enters EX one cycle later, with the load in WB for forwarding.
- Reset asserted mid-stall clears state immediately. The stall outputs drop in that same cycle.
- There are no multi-cycle paths.

## Test plan
- Reset sequence: drive rst_n low mid-cycle → all outputs 0 asynchronously; release, then apply rd_d = 5, regwrite_d = 1 → rd_e = 5 and valid_e = 1 one edge later.
- Load-use on rs2: EX holds a load with rd_e = 7; ID has rs2_d = 7, use_rs2_d = 1 → stall_f = stall_d = 1 for one cycle, a bubble appears in EX, stall_cnt = 1, and the instruction enters EX on the following edge.
- Non-hazards: a load with rd_e = 0 and rs1_d = 0; or rs1_d = 7 with use_rs1_d = 0; or a non-load writer in EX to rd 7 → no stall.
- Simultaneous flush_e and load_use → stall outputs 0, bubble inserted, flush_cnt += 1, stall_cnt unchanged.
- hold = 1 for 3 cycles while flush_e pulses and *_d inputs change → EX outputs and counters unchanged throughout.
- Saturation: preload 65535 stall events with CNT_W = 16, then one more → stall_cnt stays 0xFFFF.
